mul_div_unit: RTL
=================

# mul_div_unit

Iterative RV32M multiply/divide execution unit for the rv32i core. Consumes the two register-file read operands and an M-extension funct3, computes over multiple cycles, and returns a 32-bit result with a destination register number and a write-enable pulse that drives the register file's write port. The core stalls on `busy`; the unit holds one operation at a time.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `start`  input  1  request; accepted only in IDLE
- `flush`  input  1  synchronous abort; returns to IDLE, no result
- `op`  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `rs1_data`  input  32  operand A (dividend / multiplicand)
- `rs2_data`  input  32  operand B (divisor / multiplier)
- `rd_in`  input  5  destination register number, captured with the operands
- `busy`  output  1  high whenever state is not IDLE
- `done`  output  1  one-cycle result-valid pulse
- `wr_en`  output  1  register-file write enable; equals `done`
- `wr_reg`  output  5  captured `rd_in`, valid while `done`
- `result`  output  32  result, valid while `done`; holds its value until the next `done`

## Operation
- States: IDLE, CALC, DONE.
- IDLE: on `start`=1, latch `op`, `rs1_data`, `rs2_data`, `rd_in`. Special case → DONE; otherwise → CALC with the iteration counter at 0.
- CALC: one iteration per cycle, counter 0..31. After iteration 31 → DONE. `start` is ignored.
- DONE: `done`=`wr_en`=1 for exactly one cycle, then → IDLE. `start` is ignored in DONE.
- `flush`=1 in any state → IDLE next edge. `done` is not asserted, and `result`/`wr_reg` keep their previous values. `flush` takes priority over `start` and over DONE.
- Multiply: shift-add over a 64-bit product using magnitudes. Operand A is signed for MULH and MULHSU; operand B is signed for MULH only. The 64-bit product is negated when the signs differ. MUL returns bits [31:0]; the MULH* ops return bits [63:32].
- Divide: restoring division on magnitudes, 1 quotient bit per iteration, with a 33-bit partial remainder.
  - Signed ops: the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- Special cases, resolved in IDLE without CALC:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `rs1_data`.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- All arithmetic is modulo 2^32 on the returned half. No exceptions are raised.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `wr_en`=0, `wr_reg`=0, `result`=0, counter 0.
- Reset asserted mid-operation aborts immediately. No `done` follows.
- In the timeline below, `start` is sampled at edge E0.
  - Normal op: `busy` is high from E0+ and `done` is high during the cycle after E32. Latency is 33 cycles, and `busy` drops after E33.
  - Special case: `done` is high during the cycle after E0 (latency 1).
- Minimum spacing between accepted starts is latency + 1 cycles, because DONE is followed by a mandatory IDLE cycle.
- Operand inputs are don't-care after the accepting edge.

## Configuration
- `MUL_DIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU compute in a single combinational 33×33 signed multiply in IDLE and go directly to DONE (latency 1).
  - Divide ops are unchanged.
- `MUL_DIV_FAST_MUL_EN` undefined: multiply uses the 32-iteration shift-add path (latency 33).

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3), rd=5, start 1 cycle:
  - Without the macro: `done`=1 33 cycles after the start edge, with `result`=0xFFFFFFEB, `wr_reg`=5, `wr_en`=1 for one cycle.
  - With the macro: the same result 1 cycle after the start edge.
- MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF → results 0x00000000, 0x80000000 and 0x7FFFFFFF respectively.
- DIV with A=−7 (0xFFFFFFF9), B=2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU with A=100, B=7 → 14. REMU on the same operands → 2.
- Special cases:
  - DIVU A=123, B=0 → 0xFFFFFFFF, with `done` 1 cycle after start.
  - REM A=123, B=0 → 123.
  - DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000.
  - REM on the same operands → 0.
- Aborts:
  - Start DIVU, then assert `flush` at iteration 10: `busy`=0 next cycle, no `done`, and `result` unchanged.
  - Repeat the operation, but drop `rst_n` mid-CALC: all outputs read 0 asynchronously.
- Assert `start` while `busy` and in the DONE cycle with different operands: the request is ignored, and the first result completes unaltered. A start on the following IDLE cycle is accepted.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: 33-cycle latency, 1 for div-by-zero/overflow (and multiply under MUL_DIV_FAST_MUL_EN).
// No backpressure: the core stalls on o_busy, one operation in flight; i_flush aborts with no result.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_in,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_wr_en,
  output logic [4:0]      o_wr_reg,
  output logic [XLEN-1:0] o_result
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [4:0]  r_rd, r_wr_reg;
  logic        r_neg_q, r_neg_r;
  logic [31:0] r_b, r_sh, r_rem, r_res_calc, r_result;
  logic [63:0] r_mcand, r_acc;

  logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag;
  logic        w_div0, w_ovf, w_special, w_fast;
  logic [31:0] w_special_val, w_fast_val;

  assign w_a_signed = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
  assign w_b_signed = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
  assign w_a_neg    = w_a_signed & i_rs1_data[31];
  assign w_b_neg    = w_b_signed & i_rs2_data[31];
  assign w_a_mag    = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_b_mag    = w_b_neg ? -i_rs2_data : i_rs2_data;

  assign w_div0    = i_op[2] && (i_rs2_data == 32'd0);
  assign w_ovf     = i_op[2] && !i_op[0] && (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
  assign w_special = w_div0 || w_ovf;
  assign w_special_val = w_div0 ? (i_op[1] ? i_rs1_data : 32'hFFFF_FFFF)
                                : (i_op[1] ? 32'd0 : 32'h8000_0000);

`ifdef MUL_DIV_FAST_MUL_EN
  // 64-bit product of the sign/zero-extended 33-bit operands; both halves are exact.
  logic signed [63:0] w_fa, w_fb, w_fprod;
  assign w_fa       = {{32{w_a_neg}}, i_rs1_data};
  assign w_fb       = {{32{w_b_neg}}, i_rs2_data};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast     = !i_op[2];
  assign w_fast_val = (i_op == 3'd0) ? w_fprod[31:0] : w_fprod[63:32];
`else
  assign w_fast     = 1'b0;
  assign w_fast_val = 32'd0;
`endif

  logic [63:0] w_acc_nxt, w_prod_fin;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_nxt, w_quo_nxt, w_quo_fin, w_rem_fin, w_final;

  assign w_acc_nxt  = r_sh[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh   = {r_rem, r_sh[31]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  // The difference is below r_b when taken, so 32 bits hold it exactly.
  assign w_rem_nxt  = w_ge ? (w_rem_sh[31:0] - r_b) : w_rem_sh[31:0];
  assign w_quo_nxt  = {r_sh[30:0], w_ge};
  assign w_prod_fin = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_fin  = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fin  = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_final    = r_op[2] ? (r_op[1] ? w_rem_fin : w_quo_fin)
                              : ((r_op == 3'd0) ? w_prod_fin[31:0] : w_prod_fin[63:32]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = (r_state != S_IDLE);
    o_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (w_special || w_fast) ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      S_DONE: begin
        w_state_nxt = S_IDLE;
        o_done      = !i_flush;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
    o_wr_en  = o_done;
    o_result = o_done ? r_res_calc : r_result;
    o_wr_reg = o_done ? r_rd : r_wr_reg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= 5'd0;
      r_op       <= 3'd0;
      r_rd       <= 5'd0;
      r_wr_reg   <= 5'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_b        <= 32'd0;
      r_sh       <= 32'd0;
      r_rem      <= 32'd0;
      r_res_calc <= 32'd0;
      r_result   <= 32'd0;
      r_mcand    <= 64'd0;
      r_acc      <= 64'd0;
    end else if (!i_flush) begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_op       <= i_op;
          r_rd       <= i_rd_in;
          r_neg_q    <= w_a_neg ^ w_b_neg;
          r_neg_r    <= w_a_neg;
          r_cnt      <= 5'd0;
          r_b        <= w_b_mag;
          r_sh       <= i_op[2] ? w_a_mag : w_b_mag;
          r_mcand    <= {32'd0, w_a_mag};
          r_acc      <= 64'd0;
          r_rem      <= 32'd0;
          r_res_calc <= w_special ? w_special_val : w_fast_val;
        end
        S_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_op[2]) begin
            r_rem <= w_rem_nxt;
            r_sh  <= w_quo_nxt;
          end else begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_sh    <= r_sh >> 1;
          end
          if (r_cnt == 5'd31) r_res_calc <= w_final;
        end
        S_DONE: begin
          r_result <= r_res_calc;
          r_wr_reg <= r_rd;
        end
        default: ;
      endcase
    end
  end
endmodule
